// File: rtl/fdivsqrt_postproc_pipe_pkg.sv
// Shared configuration for the divide/sqrt post-processing pipeline.
// DIVB is the default number of fractional quotient bits; the residual is
// carried as Q4.DIVb and the quotient pair as U1.DIVb.
package fdivsqrt_postproc_pipe_pkg;

  localparam int DIVB = 55;

  function automatic int res_w(input int divb);
    return divb + 4;
  endfunction

  function automatic int quo_w(input int divb);
    return divb + 1;
  endfunction

  localparam int RESW = res_w(DIVB);
  localparam int QW   = quo_w(DIVB);

endpackage

// File: rtl/fdivsqrt_postproc_pipe_if.sv
// Handoff bus between the iteration engine, the post-processing pipeline
// and the rounder. The slave side is the pipeline itself.
interface fdivsqrt_postproc_pipe_if
  import fdivsqrt_postproc_pipe_pkg::*;
#(
  parameter int DIVb = DIVB
) ();

  localparam int RES_W = res_w(DIVb);
  localparam int QUO_W = quo_w(DIVb);

  logic             InValid;
  logic             InReady;
  logic [RES_W-1:0] WS;
  logic [RES_W-1:0] WC;
  logic [QUO_W-1:0] U;
  logic [QUO_W-1:0] UM;
  logic             SqrtE;
  logic             OutValid;
  logic             OutReady;
  logic [QUO_W-1:0] QM;
  logic             Sticky;
  logic             RemNeg;
  logic             SqrtM;

  modport slave (
    input  InValid, WS, WC, U, UM, SqrtE, OutReady,
    output InReady, OutValid, QM, Sticky, RemNeg, SqrtM
  );

  modport master (
    output InValid, WS, WC, U, UM, SqrtE, OutReady,
    input  InReady, OutValid, QM, Sticky, RemNeg, SqrtM
  );

endinterface

// File: rtl/fdivsqrt_postproc_pipe_remsign.sv
// Remainder sign and zero detection from a (possibly redundant) residual.
// Kept as its own block so a carry-free sign/zero detector can replace the
// plain adder without touching the pipeline control.
module fdivsqrt_remsign
  import fdivsqrt_postproc_pipe_pkg::*;
#(
  parameter int DIVb = DIVB
) (
  input  logic [res_w(DIVb)-1:0] ws,
  input  logic [res_w(DIVb)-1:0] wc,
  output logic                   rem_neg,
  output logic                   rem_zero
);

  localparam int RES_W = res_w(DIVb);

  logic signed [RES_W-1:0] w;

  // Resolve the residual modulo 2^RES_W and inspect it.
  always_comb begin
    w        = $signed(ws) + $signed(wc);
    rem_neg  = (w < 0);
    rem_zero = (w == '0);
  end

endmodule

// File: rtl/fdivsqrt_postproc_pipe.sv
// Divide/sqrt post-processing: resolves the final residual, picks U or UM
// depending on the remainder sign and produces sticky for the rounder.
// Two valid/ready stages, no skid buffer; InReady depends on OutReady.
module fdivsqrt_postproc_pipe
  import fdivsqrt_postproc_pipe_pkg::*;
#(
  parameter int DIVb = DIVB
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  fdivsqrt_postproc_pipe_if.slave   bus
);

  localparam int RES_W = res_w(DIVb);
  localparam int QUO_W = quo_w(DIVb);

  // Carry-propagate add of the redundant residual; wraps by construction.
  function automatic logic signed [RES_W-1:0] resid_add(
    input logic signed [RES_W-1:0] a,
    input logic signed [RES_W-1:0] b
  );
    return a + b;
  endfunction

  logic                    vld_p1_q, vld_p1_d;
  logic                    vld_p2_q, vld_p2_d;
  logic signed [RES_W-1:0] w_p1_q, w_p1_d;
  logic [QUO_W-1:0]        u_p1_q, u_p1_d;
  logic [QUO_W-1:0]        um_p1_q, um_p1_d;
  logic                    sqrt_p1_q, sqrt_p1_d;
  logic [QUO_W-1:0]        qm_p2_q, qm_p2_d;
  logic                    sticky_p2_q, sticky_p2_d;
  logic                    neg_p2_q, neg_p2_d;
  logic                    sqrt_p2_q, sqrt_p2_d;

  logic                    s2_adv;
  logic                    s1_adv;
  logic                    in_ready;
  logic                    accept;
  logic                    rem_neg_p1;
  logic                    rem_zero_p1;

  // W is already resolved in S1, so the carry input is tied off here.
  fdivsqrt_remsign #(.DIVb(DIVb)) u_remsign (
    .ws       (w_p1_q),
    .wc       ('0),
    .rem_neg  (rem_neg_p1),
    .rem_zero (rem_zero_p1)
  );

  // Handshake, stage-advance decisions and next-state for both stages.
  always_comb begin
    s2_adv   = ~vld_p2_q | bus.OutReady;
    s1_adv   = vld_p1_q & s2_adv;
    in_ready = ~vld_p1_q | s1_adv;
    accept   = bus.InValid & in_ready;

    vld_p1_d    = vld_p1_q;
    w_p1_d      = w_p1_q;
    u_p1_d      = u_p1_q;
    um_p1_d     = um_p1_q;
    sqrt_p1_d   = sqrt_p1_q;
    vld_p2_d    = vld_p2_q;
    qm_p2_d     = qm_p2_q;
    sticky_p2_d = sticky_p2_q;
    neg_p2_d    = neg_p2_q;
    sqrt_p2_d   = sqrt_p2_q;

    // Input -> S1: capture the resolved residual and the quotient pair.
    if (accept) begin
      vld_p1_d  = 1'b1;
      w_p1_d    = resid_add($signed(bus.WS), $signed(bus.WC));
      u_p1_d    = bus.U;
      um_p1_d   = bus.UM;
      sqrt_p1_d = bus.SqrtE;
    end else if (s1_adv) begin
      vld_p1_d  = 1'b0;
    end

    // S1 -> S2: a negative remainder means the true quotient is UM.
    if (s1_adv) begin
      vld_p2_d    = 1'b1;
      qm_p2_d     = rem_neg_p1 ? um_p1_q : u_p1_q;
      sticky_p2_d = ~rem_zero_p1;
      neg_p2_d    = rem_neg_p1;
      sqrt_p2_d   = sqrt_p1_q;
    end else if (bus.OutReady) begin
      vld_p2_d    = 1'b0;
    end

    // Flush wins over any same-cycle accept or advance.
    if (flush) begin
      vld_p1_d    = 1'b0;
      vld_p2_d    = 1'b0;
      qm_p2_d     = '0;
      sticky_p2_d = 1'b0;
      neg_p2_d    = 1'b0;
      sqrt_p2_d   = 1'b0;
    end
  end

  // Stage valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // S1 data holds only while vld_p1_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    w_p1_q    <= w_p1_d;
    u_p1_q    <= u_p1_d;
    um_p1_q   <= um_p1_d;
    sqrt_p1_q <= sqrt_p1_d;
  end

  // S2 registers drive the outputs directly and read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      qm_p2_q     <= '0;
      sticky_p2_q <= 1'b0;
      neg_p2_q    <= 1'b0;
      sqrt_p2_q   <= 1'b0;
    end else begin
      qm_p2_q     <= qm_p2_d;
      sticky_p2_q <= sticky_p2_d;
      neg_p2_q    <= neg_p2_d;
      sqrt_p2_q   <= sqrt_p2_d;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.OutValid = vld_p2_q;
  assign bus.QM       = qm_p2_q;
  assign bus.Sticky   = sticky_p2_q;
  assign bus.RemNeg   = neg_p2_q;
  assign bus.SqrtM    = sqrt_p2_q;

endmodule

// File: tb/tb_fdivsqrt_postproc_pipe.sv
// Bench for fdivsqrt_postproc_pipe at DIVb=8 (12-bit residual, 9-bit quotient).
// Directed cases plus randomized traffic compared against a transaction-level
// model: a queue of accepted results, each computed with integer arithmetic.
module tb_fdivsqrt_postproc_pipe;

  localparam int DIVb = 8;
  localparam int RW   = 12;
  localparam int QW   = 9;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  fdivsqrt_postproc_pipe_if #(.DIVb(DIVb)) bus ();

  fdivsqrt_postproc_pipe #(.DIVb(DIVb)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    logic [QW-1:0] qm;
    logic          sticky;
    logic          neg;
    logic          sq;
    int            stamp;
  } ent_t;

  ent_t mq[$];
  int   cyc    = 0;
  bit   chk_en = 1'b0;

  // Expected result from the arithmetic definition: sum mod 2^12, negative
  // when the sum is at least 2^11, sticky whenever the sum is nonzero.
  function automatic ent_t mk_ent(input logic [RW-1:0] ws, input logic [RW-1:0] wc,
                                  input logic [QW-1:0] u, input logic [QW-1:0] um,
                                  input logic sq, input int stamp);
    ent_t e;
    int   sum;
    sum      = (int'(ws) + int'(wc)) % 4096;
    e.neg    = (sum >= 2048);
    e.sticky = (sum != 0);
    e.qm     = e.neg ? um : u;
    e.sq     = sq;
    e.stamp  = stamp;
    return e;
  endfunction

  // Model: at most two results in flight; the oldest is visible once it has
  // spent one edge in the pipe. Input is refused only when both are held.
  function automatic bit mdl_valid();
    return (mq.size() > 0) && (mq[0].stamp < cyc - 1);
  endfunction

  always @(posedge clk) begin
    bit rdy;
    bit vld;
    rdy = !(mq.size() == 2 && !bus.OutReady);
    vld = mdl_valid();
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (vld && bus.OutReady) void'(mq.pop_front());
      if (bus.InValid && rdy) mq.push_back(mk_ent(bus.WS, bus.WC, bus.U, bus.UM, bus.SqrtE, cyc));
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = mdl_valid();
      chk("mdl_out_valid", bus.OutValid, ev);
      chk("mdl_in_ready", bus.InReady, !(mq.size() == 2 && !bus.OutReady));
      if (ev) begin
        chk("mdl_qm", bus.QM, mq[0].qm);
        chk("mdl_sticky", bus.Sticky, mq[0].sticky);
        chk("mdl_remneg", bus.RemNeg, mq[0].neg);
        chk("mdl_sqrtm", bus.SqrtM, mq[0].sq);
      end
    end
  end

  // Present one entry and hold it until accepted (bounded wait).
  task automatic drive(input logic [RW-1:0] ws, input logic [RW-1:0] wc,
                       input logic [QW-1:0] u, input logic [QW-1:0] um, input logic sq);
    int g;
    g = 0;
    bus.InValid = 1'b1;
    bus.WS = ws; bus.WC = wc; bus.U = u; bus.UM = um; bus.SqrtE = sq;
    while (!bus.InReady && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.InValid = 1'b0;
  endtask

  // Wait (bounded) for the result and compare against fixed expectations.
  task automatic expect_out(input string tag, input logic [QW-1:0] qm,
                            input logic st, input logic neg, input logic sq);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.OutValid && n < 8);
    chk({tag, "_latency"}, n, 2);
    chk({tag, "_qm"}, bus.QM, qm);
    chk({tag, "_sticky"}, bus.Sticky, st);
    chk({tag, "_remneg"}, bus.RemNeg, neg);
    chk({tag, "_sqrtm"}, bus.SqrtM, sq);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_out_valid"}, bus.OutValid, 0);
    chk({tag, "_in_ready"}, bus.InReady, 1);
    chk({tag, "_qm"}, bus.QM, 0);
    chk({tag, "_sticky"}, bus.Sticky, 0);
    chk({tag, "_remneg"}, bus.RemNeg, 0);
    chk({tag, "_sqrtm"}, bus.SqrtM, 0);
  endtask

  initial begin
    logic [RW-1:0] r;
    reset = 1'b1; flush = 1'b0;
    bus.InValid = 1'b0; bus.WS = '0; bus.WC = '0; bus.U = '0; bus.UM = '0;
    bus.SqrtE = 1'b0; bus.OutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_zero_outs("reset");
    chk_en = 1'b1;

    // Positive, exact, negative remainders and sqrt passthrough.
    drive(12'h010, 12'h004, 9'h1A3, 9'h1A2, 1'b0);
    expect_out("pos", 9'h1A3, 1'b1, 1'b0, 1'b0);
    drive(12'h0F0, 12'hF10, 9'h100, 9'h0FF, 1'b0);
    expect_out("exact", 9'h100, 1'b0, 1'b0, 1'b0);
    drive(12'hFF0, 12'h008, 9'h155, 9'h154, 1'b0);
    expect_out("neg", 9'h154, 1'b1, 1'b1, 1'b0);
    drive(12'h002, 12'h000, 9'h0AA, 9'h0A9, 1'b1);
    expect_out("sqrt", 9'h0AA, 1'b1, 1'b0, 1'b1);

    // Back-pressure: two entries fill the pipe, the third waits.
    @(posedge clk); #1;
    drive(12'h001, 12'h001, 9'h011, 9'h010, 1'b0);
    bus.OutReady = 1'b0;
    drive(12'hFFF, 12'h000, 9'h022, 9'h021, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", bus.InReady, 0);
      chk("bp_hold_qm", bus.QM, 9'h011);
      @(posedge clk); #1;
    end
    bus.OutReady = 1'b1;
    drive(12'h100, 12'h100, 9'h033, 9'h032, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Flush with both stages occupied.
    bus.OutReady = 1'b0;
    drive(12'h005, 12'h000, 9'h044, 9'h043, 1'b0);
    drive(12'h006, 12'h000, 9'h055, 9'h054, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_zero_outs("flushA");
    bus.OutReady = 1'b1;

    // Flush in the same cycle as a presented entry: it must vanish.
    bus.InValid = 1'b1; bus.WS = 12'h007; bus.WC = 12'h000; bus.U = 9'h066; bus.UM = 9'h065;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.InValid = 1'b0; flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("flushB_out_valid", bus.OutValid, 0);
    end
    @(posedge clk); #1;

    // Reset mid-operation.
    bus.OutReady = 1'b0;
    drive(12'h008, 12'h000, 9'h077, 9'h076, 1'b1);
    drive(12'hF00, 12'h000, 9'h088, 9'h087, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero_outs("resetC");
    bus.OutReady = 1'b1;

    // Randomized traffic with random back-pressure and rare flushes.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      r = RW'($urandom);
      bus.InValid  = ($urandom_range(0, 3) != 0);
      bus.WS       = r;
      bus.WC       = ($urandom_range(0, 3) == 0) ? (~r + 12'd1) : RW'($urandom);
      bus.U        = QW'($urandom);
      bus.UM       = bus.U - 9'd1;
      bus.SqrtE    = 1'($urandom);
      bus.OutReady = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk); #1;
    bus.InValid = 1'b0; flush = 1'b0; bus.OutReady = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_out_valid", bus.OutValid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
